// File: rtl/aec_infix2postfix.sv
// Infix-to-postfix converter: buffers one '='-terminated expression, then runs
// shunting-yard over it with an 8-deep operator stack, emitting one token per cycle.
module aec_infix2postfix (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] ascii_in,
  output logic       tok_valid,
  output logic       tok_op,
  output logic [3:0] tok_val,
  output logic       done,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, RECV, CONV, FLUSH, DONE} state_t;
  typedef enum logic [2:0] {K_NUM, K_OP, K_LP, K_RP, K_EQ, K_BAD} kind_t;

  localparam logic [1:0] LPAREN = 2'd3;
  localparam logic [7:0] CH_EQ  = 8'h3D;

  function automatic kind_t kind_of(input logic [7:0] c);
    kind_t k;
    if ((c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66)) k = K_NUM;
    else if (c == 8'h2B || c == 8'h2D || c == 8'h2A)              k = K_OP;
    else if (c == 8'h28)                                           k = K_LP;
    else if (c == 8'h29)                                           k = K_RP;
    else if (c == CH_EQ)                                           k = K_EQ;
    else                                                           k = K_BAD;
    return k;
  endfunction

  // '0'-'9' carry their value in the low nibble; 'a'-'f' have low nibble 1-6
  function automatic logic [3:0] val_of(input logic [7:0] c);
    return c[3:0] + ((c <= 8'h39) ? 4'd0 : 4'd9);
  endfunction

  function automatic logic [1:0] opc_of(input logic [7:0] c);
    logic [1:0] o;
    case (c)
      8'h2B:   o = 2'd0;
      8'h2D:   o = 2'd1;
      default: o = 2'd2;
    endcase
    return o;
  endfunction

  function automatic logic prec_of(input logic [1:0] o);
    return (o == 2'd2);
  endfunction

  state_t     state_q;
  logic [3:0] wptr_q, rptr_q, sp_q;
  logic       eq_q;
  logic       tok_valid_q, tok_op_q, done_q, busy_q, err_q;
  logic [3:0] tok_val_q;
  logic [7:0] cbuf_q [16];
  logic [1:0] stk_q  [8];

  logic [7:0] cur;
  kind_t      cur_k, in_k;
  logic [1:0] cur_op, top;
  logic [3:0] sp_m1;
  logic       empty, full, last_slot, buf_we, rx_end;
  logic [3:0] buf_wa;
  logic [7:0] buf_wd;

  assign cur    = cbuf_q[rptr_q];
  assign cur_k  = kind_of(cur);
  assign cur_op = opc_of(cur);
  assign in_k   = kind_of(ascii_in);
  assign sp_m1  = sp_q - 4'd1;
  assign top    = stk_q[sp_m1[2:0]];
  assign empty  = (sp_q == 4'd0);
  assign full   = (sp_q == 4'd8);

  // Illegal characters never take a slot; slot 15 is forced to '=' to terminate.
  assign last_slot = (state_q == RECV) && (wptr_q == 4'd15);
  assign buf_we    = (((state_q == IDLE) && ready) || ((state_q == RECV) && !eq_q))
                     && (in_k != K_BAD);
  assign buf_wa    = (state_q == IDLE) ? 4'd0 : wptr_q;
  assign buf_wd    = (last_slot && in_k != K_EQ) ? CH_EQ : ascii_in;
  assign rx_end    = buf_we && ((in_k == K_EQ) || last_slot);

  logic       push, pop, emit, emit_op, adv, set_err, go_flush, to_done;
  logic [1:0] push_code;
  logic [3:0] emit_val;

  always_comb begin
    push = 1'b0; pop = 1'b0; emit = 1'b0; emit_op = 1'b0; adv = 1'b0;
    set_err = 1'b0; go_flush = 1'b0; to_done = 1'b0;
    push_code = 2'd0; emit_val = 4'd0;
    case (state_q)
      CONV: begin
        case (cur_k)
          K_NUM: begin
            emit = 1'b1; emit_val = val_of(cur); adv = 1'b1;
          end
          K_LP: begin
            push = 1'b1; push_code = LPAREN; adv = 1'b1;
          end
          K_OP: begin
            if (!empty && top != LPAREN && prec_of(top) >= prec_of(cur_op)) begin
              pop = 1'b1; emit = 1'b1; emit_op = 1'b1; emit_val = {2'b00, top};
            end else begin
              push = 1'b1; push_code = cur_op; adv = 1'b1;
            end
          end
          K_RP: begin
            if (empty) begin
              set_err = 1'b1; adv = 1'b1;
            end else if (top != LPAREN) begin
              pop = 1'b1; emit = 1'b1; emit_op = 1'b1; emit_val = {2'b00, top};
            end else begin
              pop = 1'b1; adv = 1'b1;
            end
          end
          default: go_flush = 1'b1;
        endcase
      end
      FLUSH: begin
        if (empty) begin
          to_done = 1'b1;
        end else begin
          pop = 1'b1;
          if (top != LPAREN) begin
            emit = 1'b1; emit_op = 1'b1; emit_val = {2'b00, top};
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wptr_q      <= 4'd0;
      rptr_q      <= 4'd0;
      sp_q        <= 4'd0;
      eq_q        <= 1'b0;
      tok_valid_q <= 1'b0;
      tok_op_q    <= 1'b0;
      tok_val_q   <= 4'd0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      tok_valid_q <= emit;
      done_q      <= 1'b0;
      if (emit) begin
        tok_op_q  <= emit_op;
        tok_val_q <= emit_val;
      end
      if (set_err || (push && full)) err_q <= 1'b1;
      if (push && !full) sp_q <= sp_q + 4'd1;
      else if (pop)      sp_q <= sp_m1;
      if (adv) rptr_q <= rptr_q + 4'd1;
      case (state_q)
        IDLE: if (ready) begin
          state_q <= RECV;
          busy_q  <= 1'b1;
          err_q   <= 1'b0;
          sp_q    <= 4'd0;
          rptr_q  <= 4'd0;
          eq_q    <= (in_k == K_EQ);
          wptr_q  <= (in_k != K_BAD) ? 4'd1 : 4'd0;
        end
        RECV: begin
          if (eq_q) begin
            state_q <= CONV;
          end else if (buf_we) begin
            wptr_q <= wptr_q + 4'd1;
            if (rx_end) state_q <= CONV;
          end
        end
        CONV:  if (go_flush) state_q <= FLUSH;
        FLUSH: if (to_done) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage arrays carry no reset; their pointers define what is valid.
  always_ff @(posedge clk) begin
    if (buf_we)        cbuf_q[buf_wa]    <= buf_wd;
    if (push && !full) stk_q[sp_q[2:0]] <= push_code;
  end

  assign tok_valid = tok_valid_q;
  assign tok_op    = tok_op_q;
  assign tok_val   = tok_val_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aec_infix2postfix.sv
// Directed and random expressions checked against a queue-based shunting-yard model.
module tb_aec_infix2postfix;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] ascii_in = 8'h00;
  logic       tok_valid, tok_op, done, busy, err;
  logic [3:0] tok_val;

  aec_infix2postfix dut (
    .clk(clk), .rst(rst), .ready(ready), .ascii_in(ascii_in),
    .tok_valid(tok_valid), .tok_op(tok_op), .tok_val(tok_val),
    .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  byte unsigned stim[$];
  logic [4:0]   exp_q[$];
  logic [4:0]   got_q[$];
  bit           exp_err;
  bit           seen_done, done_busy, done_tv, done_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_num(byte unsigned c);
    return (c >= "0" && c <= "9") || (c >= "a" && c <= "f");
  endfunction

  function automatic bit is_legal(byte unsigned c);
    return is_num(c) || c == "+" || c == "-" || c == "*" || c == "(" || c == ")" || c == "=";
  endfunction

  function automatic int opcode(byte unsigned c);
    return (c == "+") ? 0 : (c == "-") ? 1 : 2;
  endfunction

  function automatic int prec(int o);
    return (o == 2) ? 1 : 0;
  endfunction

  task automatic load(input string s);
    stim.delete();
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  // Reference: 3 in the stack stands for '('; operator tokens are 16 + code.
  task automatic model;
    byte unsigned b[$];
    int           stk[$];
    int           i, t;
    byte unsigned c;
    exp_q.delete();
    exp_err = 0;
    foreach (stim[k]) begin
      c = stim[k];
      if (!is_legal(c)) continue;
      if (c == "=" || b.size() == 15) begin
        b.push_back("=");
        break;
      end
      b.push_back(c);
    end
    i = 0;
    while (i < b.size() && b[i] != "=") begin
      c = b[i];
      if (is_num(c)) begin
        exp_q.push_back(5'((c <= "9") ? c - "0" : c - "a" + 10));
        i++;
      end else if (c == "(") begin
        if (stk.size() == 8) exp_err = 1; else stk.push_back(3);
        i++;
      end else if (c == ")") begin
        if (stk.size() == 0) begin
          exp_err = 1;
          i++;
        end else if (stk[$] != 3) begin
          t = stk.pop_back();
          exp_q.push_back(5'(16 + t));
        end else begin
          void'(stk.pop_back());
          i++;
        end
      end else begin
        if (stk.size() > 0 && stk[$] != 3 && prec(stk[$]) >= prec(opcode(c))) begin
          t = stk.pop_back();
          exp_q.push_back(5'(16 + t));
        end else begin
          if (stk.size() == 8) exp_err = 1; else stk.push_back(opcode(c));
          i++;
        end
      end
    end
    while (stk.size() > 0) begin
      t = stk.pop_back();
      if (t != 3) exp_q.push_back(5'(16 + t));
    end
  endtask

  task automatic grab;
    if (tok_valid) got_q.push_back({tok_op, tok_val});
    if (done && !seen_done) begin
      seen_done = 1;
      done_busy = busy;
      done_tv   = tok_valid;
      done_err  = err;
    end
  endtask

  task automatic run(input string tag, input bit pulse_mid);
    model();
    got_q.delete();
    seen_done = 0;
    ready = 1'b1;
    ascii_in = stim[0];
    tick();
    check({tag, " busy@start"}, busy, 1);
    check({tag, " err@start"}, err, 0);
    grab();
    ready = 1'b0;
    for (int k = 1; k < stim.size(); k++) begin
      ascii_in = stim[k];
      tick();
      grab();
    end
    for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
      if (pulse_mid && cyc == 2) ready = 1'b1;
      tick();
      ready = 1'b0;
      grab();
    end
    check({tag, " done seen"}, seen_done, 1);
    check({tag, " tok count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s tok%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, " busy@done"}, done_busy, 1);
    check({tag, " tok_valid@done"}, done_tv, 0);
    check({tag, " err@done"}, done_err, exp_err);
    tick();
    check({tag, " busy after"}, busy, 0);
    check({tag, " done after"}, done, 0);
  endtask

  string pool = "0123456789abcdef+-*()+-*x ";

  initial begin
    #3 rst = 1'b0;
    #4;
    check("rst tok_valid", tok_valid, 0);
    check("rst tok_op", tok_op, 0);
    check("rst tok_val", tok_val, 0);
    check("rst done", done, 0);
    check("rst busy", busy, 0);
    check("rst err", err, 0);
    #10 rst = 1'b1;
    tick();

    load("3+4*2=");
    run("prec", 0);
    check("prec const count", got_q.size(), 5);
    if (got_q.size() == 5) begin
      check("prec const t3", got_q[3], 5'h12);
      check("prec const t4", got_q[4], 5'h10);
    end

    load("(1+2)*3=");
    run("paren", 0);

    load("a-b-c=");
    run("assoc", 0);
    if (got_q.size() == 5) begin
      check("assoc const t0", got_q[0], 5'h0a);
      check("assoc const t2", got_q[2], 5'h11);
      check("assoc const t4", got_q[4], 5'h11);
    end

    load("(((((((((1=");
    run("ovf", 0);
    check("ovf err sticky", err, 1);
    load("2=");
    run("ovf clear", 0);

    load("1)+2=");
    run("rparen empty", 0);

    load("7 +x8=");
    run("illegal", 0);

    // Reset during CONV
    load("1+2=");
    ready = 1'b1;
    ascii_in = "1";
    tick();
    ready = 1'b0;
    for (int k = 1; k < 4; k++) begin
      ascii_in = stim[k];
      tick();
    end
    tick();
    #2 rst = 1'b0;
    #1;
    check("midrst tok_valid", tok_valid, 0);
    check("midrst tok_val", tok_val, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst err", err, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("midrst no done", done, 0);
    end
    load("5=");
    run("after rst", 0);

    load("1+2+3+4+5+6+7+89+");
    run("stream17", 1);
    check("stream17 const count", got_q.size(), 15);

    for (int r = 0; r < 8; r++) begin
      int len;
      len = $urandom_range(2, 14);
      stim.delete();
      for (int k = 0; k < len; k++) stim.push_back(pool[$urandom_range(0, pool.len() - 1)]);
      stim.push_back("=");
      run($sformatf("rand%0d", r), r[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
